// File: rtl/morse_tone_sequencer.sv
// morse_tone_sequencer
//   Plays one Morse character per request on the piezo PWM generator. Each
//   symbol becomes a one-cycle piezo_enable pulse carrying duration (ms) and
//   frequency (Hz). The generator has no done output, so this block times the
//   tones, the inter-symbol gaps and the character gap itself.
//
//   Optional feature macro: MORSE_SEQ_CLICK_EN (adds click_req and a short
//   key-click tone issued from IDLE).
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   code_valid/code_ready  character handshake (ready only in IDLE)
//   code_len, code_bits    symbol count (0 = word space, >5 clamps to 5);
//                          bit0 = first symbol, 1 = dash, 0 = dot
//   abort                  drop the remaining symbols of the current character
//   busy                   inverse of code_ready
//   done, aborted          one-cycle completion pulse, aborted qualifies it
//   piezo_enable           one-cycle start pulse to piezo_controller
//   piezo_duration/_freq   tone parameters, held until the next enable
//   click_req              (MORSE_SEQ_CLICK_EN only) key-click request
//
// state | meaning
// IDLE  | ready for a code (or a click request)
// TONE  | enable pulse cycle; tone timer already running
// TWAIT | remainder of the tone duration
// GAP   | 1-unit inter-symbol gap
// CGAP  | 3-unit character gap
// WGAP  | 7-unit word space, no tone
// FIN   | done pulse
// CLICK | click tone plus 1 ms margin (click build only)
module morse_tone_sequencer #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UNIT_MS  = 100,
  parameter int TONE_HZ  = 800,
  parameter int CLICK_MS = 20,
  parameter int CLICK_HZ = 2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        code_valid,
  output logic        code_ready,
  input  logic [2:0]  code_len,
  input  logic [4:0]  code_bits,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic        piezo_enable,
  output logic [15:0] piezo_duration,
  output logic [15:0] piezo_frequency
`ifdef MORSE_SEQ_CLICK_EN
  ,
  input  logic        click_req
`endif
);

  localparam int TICK    = CLK_FREQ / 1000;
  localparam int PRESC_W = (TICK > 1) ? $clog2(TICK) : 1;
  // 7 units can exceed 16 bits when 3 units just fit.
  localparam int MS_W    = 20;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK - 1);
  localparam logic [MS_W-1:0]    GAP_MS     = MS_W'(UNIT_MS);
  localparam logic [MS_W-1:0]    CGAP_MS    = MS_W'(3 * UNIT_MS);
  localparam logic [MS_W-1:0]    WGAP_MS    = MS_W'(7 * UNIT_MS);
  localparam logic [15:0]        DOT_DUR    = 16'(UNIT_MS);
  localparam logic [15:0]        DASH_DUR   = 16'(3 * UNIT_MS);
  localparam logic [15:0]        TONE_FREQ  = 16'(TONE_HZ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TONE,
    S_TWAIT,
    S_GAP,
    S_CGAP,
    S_WGAP,
    S_FIN
`ifdef MORSE_SEQ_CLICK_EN
    ,
    S_CLICK
`endif
  } state_t;

  state_t             state;
  logic [PRESC_W-1:0] presc;
  logic [MS_W-1:0]    ms_cnt;
  logic [2:0]         len_q;
  logic [4:0]         bits_q;
  logic [2:0]         sym_idx;
  logic               abort_q;

  logic [MS_W-1:0]    target;
  logic               tick;
  logic               ms_done;
  logic               last_sym;
  state_t             tone_next;

`ifdef MORSE_SEQ_CLICK_EN
  localparam logic [MS_W-1:0] CLICK_WAIT_MS = MS_W'(CLICK_MS + 1);
  localparam logic [15:0]     CLICK_DUR     = 16'(CLICK_MS);
  localparam logic [15:0]     CLICK_FREQ    = 16'(CLICK_HZ);
`else
  logic unused_click_params;
  assign unused_click_params = ^{CLICK_MS[0], CLICK_HZ[0]};
`endif

  assign code_ready = (state == S_IDLE);
  assign busy       = ~code_ready;

  always_comb begin
    target = '0;
    case (state)
      S_TONE, S_TWAIT: target = {{(MS_W-16){1'b0}}, piezo_duration};
      S_GAP:           target = GAP_MS;
      S_CGAP:          target = CGAP_MS;
      S_WGAP:          target = WGAP_MS;
`ifdef MORSE_SEQ_CLICK_EN
      S_CLICK:         target = CLICK_WAIT_MS;
`endif
      default:         target = '0;
    endcase
  end

  // The cycle that completes ms number "target" is the last cycle of the wait.
  assign tick     = (presc == PRESC_LAST);
  assign ms_done  = tick && ((ms_cnt + 1'b1) == target);
  assign last_sym = (sym_idx == (len_q - 3'd1));
  // An abort during the tone lets the tone finish, then skips to the char gap.
  assign tone_next = (abort_q || abort || last_sym) ? S_CGAP : S_GAP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      presc           <= '0;
      ms_cnt          <= '0;
      len_q           <= '0;
      bits_q          <= '0;
      sym_idx         <= '0;
      abort_q         <= 1'b0;
      done            <= 1'b0;
      aborted         <= 1'b0;
      piezo_enable    <= 1'b0;
      piezo_duration  <= '0;
      piezo_frequency <= '0;
    end else begin
      piezo_enable <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;

      if (tick) begin
        presc  <= '0;
        ms_cnt <= ms_cnt + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end

      case (state)
        S_IDLE: begin
          presc  <= '0;
          ms_cnt <= '0;
          if (code_valid) begin
            abort_q <= 1'b0;
            sym_idx <= '0;
            bits_q  <= code_bits;
            len_q   <= (code_len > 3'd5) ? 3'd5 : code_len;
            if (code_len == 3'd0) begin
              state <= S_WGAP;
            end else begin
              state           <= S_TONE;
              piezo_enable    <= 1'b1;
              piezo_duration  <= code_bits[0] ? DASH_DUR : DOT_DUR;
              piezo_frequency <= TONE_FREQ;
            end
          end
`ifdef MORSE_SEQ_CLICK_EN
          else if (click_req) begin
            state           <= S_CLICK;
            piezo_enable    <= 1'b1;
            piezo_duration  <= CLICK_DUR;
            piezo_frequency <= CLICK_FREQ;
          end
`endif
        end

        S_TONE, S_TWAIT: begin
          if (abort) abort_q <= 1'b1;
          if (ms_done) begin
            state  <= tone_next;
            presc  <= '0;
            ms_cnt <= '0;
          end else begin
            state <= S_TWAIT;
          end
        end

        S_GAP: begin
          if (abort) begin
            abort_q <= 1'b1;
            state   <= S_CGAP;
            presc   <= '0;
            ms_cnt  <= '0;
          end else if (ms_done) begin
            state           <= S_TONE;
            sym_idx         <= sym_idx + 3'd1;
            bits_q          <= bits_q >> 1;
            piezo_enable    <= 1'b1;
            piezo_duration  <= bits_q[1] ? DASH_DUR : DOT_DUR;
            piezo_frequency <= TONE_FREQ;
            presc           <= '0;
            ms_cnt          <= '0;
          end
        end

        S_CGAP, S_WGAP: begin
          if (ms_done) begin
            state   <= S_FIN;
            done    <= 1'b1;
            aborted <= abort_q;
          end
        end

        S_FIN: begin
          state  <= S_IDLE;
          presc  <= '0;
          ms_cnt <= '0;
        end

`ifdef MORSE_SEQ_CLICK_EN
        S_CLICK: begin
          if (ms_done) state <= S_IDLE;
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
